uart_bus_bridge: RTL
====================

Name: uart_bus_bridge

Overview:
- UART-driven bus initiator: receives command frames over a serial line, issues single-word read/write accesses on the core-side MMIO/memory bus, and returns results over serial.
- Debug and program-load path: the host pokes peripherals and memory without CPU involvement.
- Sits beside the CPU as a second bus master; o_active lets the top-level interconnect stall the CPU and mux this block onto the bus.

Parameters:
CLOCK_HZ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate; 8N1, LSB first, line idles high
TIMEOUT_CYCLES, 5_000_000, max clocks between bytes of one frame before abort (must be >= 1)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_uart_rx  input  1  serial in from host; double-flop synchronised internally
o_uart_tx  output  1  serial out to host
o_mmio_addr  output  32  bus address
o_mmio_data_out  output  32  bus write data
i_mmio_data_in  input  32  bus read data, combinational from responder
o_mmio_we  output  1  write strobe, one cycle
o_mmio_re  output  1  read strobe, one cycle
o_active  output  1  high while a frame is in progress
o_err_pulse  output  1  one-cycle pulse on NAK or timeout

Behaviour:
- Reset (i_rst_n low, async): FSM=IDLE, counters 0, o_uart_tx=1, o_mmio_* all 0, o_active=0, o_err_pulse=0. Reset mid-frame or mid-transmit: frame discarded, TX line returns high immediately.
- Serial RX/TX via team uart_rx/uart_tx with same CLOCK_HZ/BAUD_RATE; internal reset derived from i_rst_n. RX bytes consumed (read_ack) only in IDLE, ADDR, DATA; bytes arriving in EXEC/RESP stay in the receiver's 1-byte buffer; further arrivals during that time are lost.
- Frame format, multi-byte fields little-endian:
  - 'W' (0x57), addr[4], data[4] -> bus write, respond 0x06.
  - 'R' (0x52), addr[4] -> bus read, respond 4 data bytes, LS byte first.
  - Any other first byte -> respond 0x15 (NAK), pulse o_err_pulse, return to IDLE.
- FSM:
  - IDLE: on byte: 'W'/'R' -> ADDR, cnt=0; else -> RESP with NAK.
  - ADDR: shift byte into addr[8*cnt +: 8]; at cnt=3 -> DATA for W, EXEC for R.
  - DATA: same accumulation into wdata; at cnt=3 -> EXEC.
  - EXEC: exactly one cycle.
    - W: o_mmio_we=1, o_mmio_addr/o_mmio_data_out valid.
    - R: o_mmio_re=1; i_mmio_data_in captured at the end of this cycle.
    - -> RESP.
  - RESP: present next response byte to TX when tx not busy; advance on accept; after last byte -> WAIT_TX.
  - WAIT_TX: -> IDLE when tx not busy (final stop bit complete).
- o_active=1 in every state except IDLE; asserted the cycle after the first valid command byte is accepted.
- o_mmio_addr/o_mmio_data_out hold their last values outside EXEC; strobes are 0 outside EXEC.
- No alignment check: address is passed through unchanged.
- Timeout: in ADDR/DATA, counter reset on each accepted byte. Reaching TIMEOUT_CYCLES -> IDLE, no bus access, no response, o_err_pulse one cycle.
- Latency: EXEC occurs 1–2 cycles after the final frame byte's rx valid; first response start bit begins within 2 cycles after EXEC.

Test Plan:
- Use CLOCK_HZ=1_000_000, BAUD_RATE=100_000 (10 clk/bit).
- Reset mid-stream: hold i_rst_n low during byte 3 of a W frame -> o_uart_tx=1, o_active=0; the next full frame executes normally.
- Write: send 57 00 00 00 10 EF BE AD DE -> exactly one cycle o_mmio_we=1, addr=0x1000_0000, data=0xDEADBEEF; host receives 0x06; o_active falls after the stop bit.
- Read: responder returns 0x12345678 at 0x0000_0040; send 52 40 00 00 00 -> one-cycle o_mmio_re with addr=0x40; host receives 78 56 34 12.
- Bad command: send 0x41 -> host receives 0x15, o_err_pulse once, no strobes; an immediately following valid R frame succeeds.
- Timeout: with TIMEOUT_CYCLES=500, send 57 00 then idle 600 clk -> o_err_pulse, no we, no response; then a full valid W frame executes correctly.
- Back-to-back: send R frame, then W frame starting during the R response -> W frame's first byte is buffered; both execute in order, four data bytes then 0x06.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// UART-driven single-word bus initiator: command frames in over serial, MMIO access,
// result bytes back out. Contains its own 8N1 receiver and transmitter.

module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic          rx_meta, rx_sync;
  logic          busy;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] tmr;
  logic [7:0]    shreg;
  logic          stop_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // bit_cnt: 0 = start, 1..8 = data, 9 = stop; sampling at mid-bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy    <= 1'b0;
      bit_cnt <= '0;
      tmr     <= '0;
      shreg   <= '0;
    end else if (!busy) begin
      if (!rx_sync) begin
        busy    <= 1'b1;
        bit_cnt <= '0;
        tmr     <= CW'(CLKS_PER_BIT / 2 - 1);
      end
    end else if (tmr != '0) begin
      tmr <= tmr - 1'b1;
    end else begin
      tmr <= CW'(CLKS_PER_BIT - 1);
      if (bit_cnt == 4'd0) begin
        if (rx_sync) busy <= 1'b0;
        else         bit_cnt <= 4'd1;
      end else if (bit_cnt == 4'd9) begin
        busy <= 1'b0;
      end else begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign stop_ok = busy && (tmr == '0) && (bit_cnt == 4'd9) && rx_sync;

  // One-byte holding buffer; a byte completing while it is full is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (stop_ok && (!o_valid || i_ack)) begin
      o_data  <= shreg;
      o_valid <= 1'b1;
    end else if (i_ack) begin
      o_valid <= 1'b0;
    end
  end
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [8:0]    sh;
  logic [3:0]    bits_left;
  logic [CW-1:0] tmr;

  assign o_busy = (bits_left != 4'd0);

  // busy drops exactly when the stop bit has been on the line for a full bit time
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx      <= 1'b1;
      sh        <= '1;
      bits_left <= '0;
      tmr       <= '0;
    end else if (i_start && !o_busy) begin
      o_tx      <= 1'b0;
      sh        <= {1'b1, i_data};
      bits_left <= 4'd10;
      tmr       <= CW'(CLKS_PER_BIT - 1);
    end else if (o_busy) begin
      if (tmr != '0) begin
        tmr <= tmr - 1'b1;
      end else begin
        tmr       <= CW'(CLKS_PER_BIT - 1);
        o_tx      <= sh[0];
        sh        <= {1'b1, sh[8:1]};
        bits_left <= bits_left - 1'b1;
      end
    end
  end
endmodule

// state   | meaning
// IDLE    | waiting for a command byte
// ADDR    | collecting 4 address bytes, LS first
// DATA    | collecting 4 write-data bytes, LS first
// EXEC    | single bus strobe cycle
// RESP    | handing response bytes to the transmitter
// WAIT_TX | letting the last stop bit finish
module uart_bus_bridge #(
  parameter int CLOCK_HZ       = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic [31:0] o_mmio_addr,
  output logic [31:0] o_mmio_data_out,
  input  logic [31:0] i_mmio_data_in,
  output logic        o_mmio_we,
  output logic        o_mmio_re,
  output logic        o_active,
  output logic        o_err_pulse
);
  localparam int          CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam logic [31:0] TMR_LOAD     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  CMD_W = 8'h57, CMD_R = 8'h52;
  localparam logic [7:0]  ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, EXEC, RESP, WAIT_TX} state_t;
  state_t state, nxt;

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ack;
  logic        tx_start, tx_busy;
  logic [7:0]  tx_data;
  logic        err_set;

  logic [1:0]  cnt, resp_idx, resp_last;
  logic        is_write, resp_nak;
  logic [31:0] addr, rdata, tmr;
  logic [23:0] wdata;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_rx   (i_uart_rx),
    .i_ack  (rx_ack),
    .o_data (rx_data),
    .o_valid(rx_valid)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(tx_start),
    .i_data (tx_data),
    .o_busy (tx_busy),
    .o_tx   (o_uart_tx)
  );

  assign resp_last = (resp_nak || is_write) ? 2'd0 : 2'd3;
  assign tx_data   = resp_nak ? NAK : (is_write ? ACK : rdata[7:0]);
  assign o_mmio_we = (state == EXEC) && is_write;
  assign o_mmio_re = (state == EXEC) && !is_write;
  assign o_active  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt      = state;
    rx_ack   = 1'b0;
    tx_start = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          rx_ack = 1'b1;
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            nxt = ADDR;
          end else begin
            nxt     = RESP;
            err_set = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          rx_ack = 1'b1;
          if (cnt == 2'd3) nxt = is_write ? DATA : EXEC;
        end else if (tmr == '0) begin
          nxt     = IDLE;
          err_set = 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          rx_ack = 1'b1;
          if (cnt == 2'd3) nxt = EXEC;
        end else if (tmr == '0) begin
          nxt     = IDLE;
          err_set = 1'b1;
        end
      end
      EXEC: nxt = RESP;
      RESP: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          if (resp_idx == resp_last) nxt = WAIT_TX;
        end
      end
      WAIT_TX: if (!tx_busy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Fields shift in from the top so little-endian bytes land in place after the last one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt             <= '0;
      resp_idx        <= '0;
      is_write        <= 1'b0;
      resp_nak        <= 1'b0;
      addr            <= '0;
      wdata           <= '0;
      rdata           <= '0;
      tmr             <= '0;
      o_mmio_addr     <= '0;
      o_mmio_data_out <= '0;
      o_err_pulse     <= 1'b0;
    end else begin
      o_err_pulse <= err_set;
      if (rx_ack) begin
        tmr <= TMR_LOAD;
        case (state)
          IDLE: begin
            is_write <= (rx_data == CMD_W);
            resp_nak <= !(rx_data == CMD_W || rx_data == CMD_R);
            cnt      <= '0;
            resp_idx <= '0;
          end
          ADDR: begin
            addr <= {rx_data, addr[31:8]};
            cnt  <= cnt + 1'b1;
            if (cnt == 2'd3 && !is_write) o_mmio_addr <= {rx_data, addr[31:8]};
          end
          DATA: begin
            wdata <= {rx_data, wdata[23:8]};
            cnt   <= cnt + 1'b1;
            if (cnt == 2'd3) begin
              o_mmio_addr     <= addr;
              o_mmio_data_out <= {rx_data, wdata};
            end
          end
          default: ;
        endcase
      end else if ((state == ADDR || state == DATA) && tmr != '0) begin
        tmr <= tmr - 1'b1;
      end
      if (state == EXEC && !is_write) rdata <= i_mmio_data_in;
      if (tx_start) begin
        resp_idx <= resp_idx + 1'b1;
        rdata    <= {8'h00, rdata[31:8]};
      end
    end
  end
endmodule
